// File: rtl/wave_capture_if.sv
// wave_capture_if: sample-in / RAM-write bundle for the wave_capture block.
//   new_sample_ready   one-cycle strobe, new_sample_in valid this cycle
//   new_sample_in      signed 16-bit audio sample
//   wave_display_idle  high while the display scan is outside the waveform region
//   write_address      {~read_index, offset[7:0]} into the shared sample RAM
//   write_enable       one-cycle RAM write strobe
//   write_sample       offset-binary 8-bit sample
//   read_index         half-buffer currently owned by the display
// Modports: master = sample source / display side, slave = wave_capture.
interface wave_capture_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: triggered oscilloscope-style capture into a double-buffered sample RAM.
// Waits for a negative-to-non-negative crossing, then writes 256 consecutive samples
// into the half-buffer the display is not reading. Once full, it waits for the display
// to go idle, swaps halves and re-arms.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      wave_capture_if.slave (sample input, display idle, RAM write port, read_index)
// Optional feature: define WAVE_CAPTURE_AUTOTRIG_EN to force a trigger after 4096
// strobes in the armed state without a crossing.
module wave_capture (
  input logic           clk,
  input logic           reset_n,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {StArmed, StActive, StWait} state_e;

  state_e     r_state;
  logic [7:0] r_count;
  logic       r_prev_neg;
  logic       r_read_index;
  logic       r_write_enable;
  logic [8:0] r_write_address;
  logic [7:0] r_write_sample;

  logic       w_sample_neg;
  logic       w_trigger;
  logic       w_accept;
  logic [7:0] w_offset;
  logic       w_unused;

  assign w_sample_neg = bus.new_sample_in[15];
  // Low byte is dropped by the 8-bit RAM format.
  assign w_unused     = ^bus.new_sample_in[7:0];

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  logic [11:0] r_idle_cnt;
  // The 4096th untriggered strobe arrives while the counter holds 4095.
  assign w_trigger = (r_prev_neg & ~w_sample_neg) | (r_idle_cnt == 12'hFFF);
`else
  assign w_trigger = r_prev_neg & ~w_sample_neg;
`endif

  // The triggering sample always lands at offset 0.
  assign w_offset = (r_state == StArmed) ? 8'd0 : r_count;
  assign w_accept = bus.new_sample_ready &
                    (((r_state == StArmed) & w_trigger) | (r_state == StActive));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StArmed;
      r_count         <= 8'd0;
      r_prev_neg      <= 1'b0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= 9'd0;
      r_write_sample  <= 8'd0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      r_idle_cnt      <= 12'd0;
`endif
    end else begin
      r_write_enable <= 1'b0;
      if (w_accept) begin
        r_write_enable  <= 1'b1;
        r_write_address <= {~r_read_index, w_offset};
        r_write_sample  <= {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
        r_count         <= w_offset + 8'd1;  // wraps to 0 after offset 255
      end

      unique case (r_state)
        StArmed: begin
          if (bus.new_sample_ready) begin
            r_prev_neg <= w_sample_neg;
            if (w_trigger) begin
              r_state <= StActive;
            end
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            r_idle_cnt <= w_trigger ? 12'd0 : r_idle_cnt + 12'd1;
`endif
          end
        end
        StActive: begin
          if (bus.new_sample_ready) begin
            r_prev_neg <= w_sample_neg;
            if (r_count == 8'hFF) begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          // Swap halves only while the display is away from the waveform.
          if (bus.wave_display_idle) begin
            r_read_index <= ~r_read_index;
            r_prev_neg   <= 1'b0;
            r_state      <= StArmed;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            r_idle_cnt   <= 12'd0;
`endif
          end
        end
        default: r_state <= StArmed;
      endcase
    end
  end

  assign bus.write_enable  = r_write_enable;
  assign bus.write_address = r_write_address;
  assign bus.write_sample  = r_write_sample;
  assign bus.read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed-vector bench for wave_capture with a behavioural
// capture model checked against the DUT on every falling clock edge.
module tb_wave_capture;
  logic clk = 1'b0;
  logic reset_n;

  wave_capture_if bus ();

  wave_capture u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks capture progress as "samples written so far"
  // and which half the display owns; produces the expected registered outputs.
  bit m_capturing = 0;
  bit m_waiting   = 0;
  bit m_prev_neg  = 0;
  int m_written   = 0;
  int m_half      = 0;
  int m_idle      = 0;
  int exp_we      = 0;
  int exp_addr    = 0;
  int exp_sample  = 0;
  int exp_ridx    = 0;

  always @(posedge clk or negedge reset_n) begin : model_step
    int s;
    bit neg;
    if (!reset_n) begin
      m_capturing = 0; m_waiting = 0; m_prev_neg = 0;
      m_written = 0; m_half = 0; m_idle = 0;
      exp_we = 0; exp_addr = 0; exp_sample = 0; exp_ridx = 0;
    end else begin
      s   = int'($signed(bus.new_sample_in));
      neg = (s < 0);
      exp_we = 0;
      if (m_waiting) begin
        if (bus.wave_display_idle) begin
          m_half = 1 - m_half;
          m_waiting = 0; m_prev_neg = 0; m_idle = 0;
        end
      end else if (bus.new_sample_ready) begin
        if (!m_capturing) begin
          if (m_prev_neg && !neg) begin
            m_capturing = 1; m_written = 0; m_idle = 0;
          end
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
          else begin
            m_idle++;
            if (m_idle == 4096) begin
              m_capturing = 1; m_written = 0; m_idle = 0;
            end
          end
`endif
        end
        m_prev_neg = neg;
        if (m_capturing) begin
          exp_we     = 1;
          exp_addr   = (1 - m_half) * 256 + m_written;
          exp_sample = ((s >>> 8) + 128) & 255;
          m_written++;
          if (m_written == 256) begin
            m_capturing = 0; m_waiting = 1;
          end
        end
      end
      exp_ridx = m_half;
    end
  end

  always @(negedge clk) begin
    check("write_enable", 32'(bus.write_enable), 32'(exp_we));
    check("write_address", 32'(bus.write_address), 32'(exp_addr));
    check("write_sample", 32'(bus.write_sample), 32'(exp_sample));
    check("read_index", 32'(bus.read_index), 32'(exp_ridx));
    if (bus.write_enable === 1'b1) dut_writes++;
  end

  // n consecutive strobes of s; returns 1 ns after the edge that took the last one.
  task automatic burst(input logic [15:0] s, input int n);
    @(posedge clk); #1;
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] s);
    burst(s, 1);
  endtask

  task automatic idle_pulse(input int n);
    @(posedge clk); #1;
    bus.wave_display_idle = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.wave_display_idle = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 16'h0000;
    bus.wave_display_idle = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset write_enable", 32'(bus.write_enable), 32'd0);
    check("reset write_address", 32'(bus.write_address), 32'd0);
    check("reset write_sample", 32'(bus.write_sample), 32'd0);
    check("reset read_index", 32'(bus.read_index), 32'd0);
    reset_n = 1'b1;

    // Display idle while armed must not swap halves.
    idle_pulse(2);
    check("idle ignored in armed", 32'(bus.read_index), 32'd0);

    // -5 then +3 crossing triggers at offset 0 of half 1.
    strobe(16'hFFFB);
    check("no write on negative", 32'(bus.write_enable), 32'd0);
    strobe(16'h0003);
    check("trigger write_enable", 32'(bus.write_enable), 32'd1);
    check("trigger write_address", 32'(bus.write_address), 32'h100);
    check("trigger write_sample", 32'(bus.write_sample), 32'h80);
    check("model trigger address", 32'(exp_addr), 32'h100);

    // Back-to-back strobes fill offsets 1..255.
    burst(16'h7F00, 255);
    check("last write_enable", 32'(bus.write_enable), 32'd1);
    check("last write_address", 32'(bus.write_address), 32'h1FF);
    check("last write_sample", 32'(bus.write_sample), 32'hFF);
    check("model last sample", 32'(exp_sample), 32'hFF);

    // Full: further strobes are ignored and outputs hold.
    burst(16'h7F00, 3);
    check("wait no write", 32'(bus.write_enable), 32'd0);
    check("wait hold address", 32'(bus.write_address), 32'h1FF);
    check("wait read_index", 32'(bus.read_index), 32'd0);

    idle_pulse(1);
    check("swap read_index", 32'(bus.read_index), 32'd1);

    // Second capture goes into half 0.
    strobe(16'hFFFF);
    strobe(16'h0000);
    check("half0 write_address", 32'(bus.write_address), 32'h000);
    check("half0 write_sample", 32'(bus.write_sample), 32'h80);
    burst(16'h1234, 100);
    check("offset100 address", 32'(bus.write_address), 32'h064);

    // Asynchronous reset mid-capture.
    #2 reset_n = 1'b0;
    #1;
    check("async write_enable", 32'(bus.write_enable), 32'd0);
    check("async write_address", 32'(bus.write_address), 32'd0);
    check("async write_sample", 32'(bus.write_sample), 32'd0);
    check("async read_index", 32'(bus.read_index), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Positive samples alone must not re-trigger after reset.
    dut_writes = 0;
    strobe(16'h0100);
    strobe(16'h0100);
    strobe(16'h0100);
    @(posedge clk); #1;
    check("no write without crossing", 32'(dut_writes), 32'd0);
    strobe(16'hFFFE);
    strobe(16'h0500);
    check("fresh trigger address", 32'(bus.write_address), 32'h100);
    check("fresh trigger sample", 32'(bus.write_sample), 32'h85);

    // Long run of positive samples from a clean reset.
    do_reset();
    dut_writes = 0;
    burst(16'h0100, 5000);
    repeat (3) @(posedge clk);
    #1;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    check("autotrig write count", 32'(dut_writes), 32'd256);
`else
    check("no autotrig write count", 32'(dut_writes), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
